// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and RAW scoreboard for the 32-entry integer register file.
// Optional write-port forwarding to decode is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             e_valid,
  output logic             e_ready,
  input  logic [4:0]       e_rd,
  input  logic [XLEN-1:0]  e_data,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [4:0]       l_rd,
  input  logic [XLEN-1:0]  l_data,
  output logic [4:0]       waddr,
  output logic             wen,
  output logic [XLEN-1:0]  wdata,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             busy1,
  output logic             busy2,
  output logic             fwd1,
  output logic             fwd2
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // last_reg = 1 means the LSU won the most recent handshake.
  logic             last_reg;
  logic             grant_e;
  logic             grant_l;
  logic             accept;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             wen_next;
  logic             alloc_fire;
  logic [CNT_W-1:0] cnt_reg  [32];
  logic [CNT_W-1:0] cnt_next [32];

  // A requester is refused only when the other one is valid and has priority.
  assign e_ready  = !(l_valid && !last_reg);
  assign l_ready  = !(e_valid && last_reg);
  assign grant_e  = e_valid && e_ready;
  assign grant_l  = l_valid && l_ready;
  assign accept   = grant_e || grant_l;
  assign sel_rd   = grant_e ? e_rd : l_rd;
  assign sel_data = grant_e ? e_data : l_data;
  assign wen_next = accept && (sel_rd != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen      <= 1'b0;
      waddr    <= 5'd0;
      wdata    <= '0;
      last_reg <= 1'b1;
    end else begin
      wen <= wen_next;
      if (wen_next) begin
        waddr <= sel_rd;
        wdata <= sel_data;
      end
      if (accept) begin
        last_reg <= grant_l;
      end
    end
  end

  // A full counter can still take an allocation when it is being drained this cycle.
  assign alloc_ready = (cnt_reg[alloc_rd] != CNT_MAX) || (wen && (waddr == alloc_rd));
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_rd != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign cnt_next[gi] = '0;
      end else begin : g_cnt
        logic inc;
        logic dec;
        assign inc = alloc_fire && (alloc_rd == 5'(gi));
        assign dec = wen && (waddr == 5'(gi));
        assign cnt_next[gi] =
            (inc && !dec && (cnt_reg[gi] != CNT_MAX)) ? cnt_reg[gi] + CNT_ONE :
            (dec && !inc && (cnt_reg[gi] != '0))      ? cnt_reg[gi] - CNT_ONE :
                                                        cnt_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

`ifdef RF_WB_FWD_EN
  // Forward only when the committing write is the sole outstanding one.
  assign fwd1  = wen && (rs1 != 5'd0) && (waddr == rs1) && (cnt_reg[rs1] == CNT_ONE);
  assign fwd2  = wen && (rs2 != 5'd0) && (waddr == rs2) && (cnt_reg[rs2] == CNT_ONE);
  assign busy1 = (cnt_reg[rs1] != '0) && !fwd1;
  assign busy2 = (cnt_reg[rs2] != '0) && !fwd2;
`else
  assign fwd1  = 1'b0;
  assign fwd2  = 1'b0;
  assign busy1 = (cnt_reg[rs1] != '0);
  assign busy2 = (cnt_reg[rs2] != '0);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (works with or without RF_WB_FWD_EN).
module tb_rf_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        e_valid = 1'b0, l_valid = 1'b0, alloc_valid = 1'b0;
  logic        e_ready, l_ready, alloc_ready, wen;
  logic [4:0]  e_rd = '0, l_rd = '0, alloc_rd = '0, rs1 = '0, rs2 = '0, waddr;
  logic [63:0] e_data = '0, l_data = '0, wdata;
  logic        busy1, busy2, fwd1, fwd2;

  int tests_run = 0;
  int tests_failed = 0;

  rf_wb_arbiter #(.XLEN(64), .CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .e_valid(e_valid), .e_ready(e_ready), .e_rd(e_rd), .e_data(e_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
    .waddr(waddr), .wen(wen), .wdata(wdata),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2), .fwd1(fwd1), .fwd2(fwd2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    e_valid = 1'b0; l_valid = 1'b0; alloc_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic exu_write(input logic [4:0] rd, input logic [63:0] d);
    e_valid = 1'b1; e_rd = rd; e_data = d;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_wen", wen, 1'b0);
    check("rst_waddr", waddr, 5'd0);
    check("rst_wdata", wdata, 64'd0);
    do_reset();
    rs1 = 5'd5; rs2 = 5'd6; alloc_rd = 5'd5; #1;
    check("rst_busy1", busy1, 1'b0);
    check("rst_fwd1", fwd1, 1'b0);
    check("rst_fwd2", fwd2, 1'b0);
    check("rst_alloc_ready", alloc_ready, 1'b1);

    // Single EXU write, 1-cycle latency, hold after
    exu_write(5'd5, 64'h1234); #1;
    check("t1_e_ready", e_ready, 1'b1);
    tick();
    e_valid = 1'b0;
    check("t1_wen", wen, 1'b1);
    check("t1_waddr", waddr, 5'd5);
    check("t1_wdata", wdata, 64'h1234);
    tick();
    check("t1_wen_off", wen, 1'b0);
    check("t1_waddr_hold", waddr, 5'd5);
    check("t1_wdata_hold", wdata, 64'h1234);
    check("t1_no_underflow", busy1, 1'b0);

    // Round-robin with both valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e_valid = 1'b1; e_rd = 5'd1; e_data = 64'(100 + i);
      l_valid = 1'b1; l_rd = 5'd2; l_data = 64'(200 + i);
      #1;
      check($sformatf("rr%0d_e_ready", i), e_ready, (i % 2 == 0));
      check($sformatf("rr%0d_l_ready", i), l_ready, (i % 2 == 1));
      tick();
      check($sformatf("rr%0d_waddr", i), waddr, (i % 2 == 0) ? 5'd1 : 5'd2);
      check($sformatf("rr%0d_wdata", i), wdata, (i % 2 == 0) ? 64'(100 + i) : 64'(200 + i));
      check($sformatf("rr%0d_wen", i), wen, 1'b1);
    end
    e_valid = 1'b0; l_valid = 1'b0;
    tick();
    check("rr_idle_wen", wen, 1'b0);

    // Saturating allocation of rd=7 and drain
    do_reset();
    rs1 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'd7; #1;
      check($sformatf("a7_ready%0d", i), alloc_ready, 1'b1);
      tick();
    end
    #1;
    check("a7_ready_full", alloc_ready, 1'b0);
    check("a7_busy1", busy1, 1'b1);
    tick();
    alloc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exu_write(5'd7, 64'(70 + i));
      tick();
    end
    e_valid = 1'b0; #1;
`ifdef RF_WB_FWD_EN
    check("a7_last_busy1", busy1, 1'b0);
    check("a7_last_fwd1", fwd1, 1'b1);
`else
    check("a7_last_busy1", busy1, 1'b1);
    check("a7_last_fwd1", fwd1, 1'b0);
`endif
    tick();
    check("a7_drained_busy1", busy1, 1'b0);

    // Full counter accepts an allocation while it is draining
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'd10;
      tick();
    end
    alloc_valid = 1'b0;
    exu_write(5'd10, 64'hA0);
    tick();
    e_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd10; #1;
    check("a10_ready_on_drain", alloc_ready, 1'b1);
    tick();
    alloc_valid = 1'b0;

    // Allocate rd=9 on the commit edge of its pending write
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick();
    alloc_valid = 1'b0;
    exu_write(5'd9, 64'h99);
    tick();
    e_valid = 1'b0;
    rs2 = 5'd9;
    alloc_valid = 1'b1; alloc_rd = 5'd9; #1;
    check("a9_alloc_ready", alloc_ready, 1'b1);
    tick();
    alloc_valid = 1'b0; #1;
    check("a9_busy2", busy2, 1'b1);
    check("a9_fwd2", fwd2, 1'b0);

    // rd=0 write: handshake, no write, scoreboard untouched
    exu_write(5'd0, 64'hFFFF); #1;
    check("rd0_e_ready", e_ready, 1'b1);
    tick();
    e_valid = 1'b0;
    check("rd0_wen", wen, 1'b0);
    check("rd0_waddr_hold", waddr, 5'd9);
    check("rd0_wdata_hold", wdata, 64'h99);
    check("rd0_busy2", busy2, 1'b1);
    e_valid = 1'b1; e_rd = 5'd1; l_valid = 1'b1; l_rd = 5'd2; #1;
    check("rd0_last_l_ready", l_ready, 1'b1);
    check("rd0_last_e_ready", e_ready, 1'b0);
    e_valid = 1'b0; l_valid = 1'b0;

    // Forwarding on a single pending write to rd=3
    do_reset();
    rs2 = 5'd3;
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_valid = 1'b0;
    exu_write(5'd3, 64'h33);
    tick();
    e_valid = 1'b0; #1;
`ifdef RF_WB_FWD_EN
    check("f3_fwd2", fwd2, 1'b1);
    check("f3_busy2", busy2, 1'b0);
`else
    check("f3_fwd2", fwd2, 1'b0);
    check("f3_busy2", busy2, 1'b1);
`endif
    tick();
    check("f3_after_busy2", busy2, 1'b0);

    // Asynchronous reset mid-operation drops the in-flight write
    rs1 = 5'd4;
    alloc_valid = 1'b1; alloc_rd = 5'd4;
    exu_write(5'd4, 64'hAB);
    tick();
    alloc_valid = 1'b0; e_valid = 1'b0;
    check("mr_wen_before", wen, 1'b1);
    reset = 1'b0; #1;
    check("mr_wen", wen, 1'b0);
    check("mr_waddr", waddr, 5'd0);
    check("mr_wdata", wdata, 64'd0);
    check("mr_busy1", busy1, 1'b0);
    reset = 1'b1;
    e_valid = 1'b1; e_rd = 5'd1; l_valid = 1'b1; l_rd = 5'd2; #1;
    check("mr_last_e_ready", e_ready, 1'b1);
    e_valid = 1'b0; l_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
